dmem_stall_resp: RTL and testbench

//  Multi-cycle data-memory responder for the MEM stage of the 16-bit 5-stage pipeline.

---
 rtl/dmem_pkg.sv | 13 +
 rtl/dmem_stall_resp_if.sv | 28 ++
 rtl/dmem_array.sv | 27 ++
 rtl/dmem_stall_resp.sv | 111 +++++++++++
 tb/tb_dmem_stall_resp.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory stall responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DMEM_LAT_DEFAULT = 4;
  localparam int CNT_W            = 4;

endpackage

// File: rtl/dmem_stall_resp_if.sv
// MEM-stage request/response bus plus a storage preload channel used to seed contents before traffic.
interface dmem_stall_resp_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] DataIn;
  logic              Rd;
  logic              Wr;
  logic              Halt;
  logic [DATA_W-1:0] DataOut;
  logic              Stall;
  logic              Done;
  logic              Err;
  logic              pre_en;
  logic [ADDR_W-2:0] pre_idx;
  logic [DATA_W-1:0] pre_dat;

  modport master (
    output Addr, DataIn, Rd, Wr, Halt, pre_en, pre_idx, pre_dat,
    input  DataOut, Stall, Done, Err
  );

  modport slave (
    input  Addr, DataIn, Rd, Wr, Halt, pre_en, pre_idx, pre_dat,
    output DataOut, Stall, Done, Err
  );
endinterface

// File: rtl/dmem_array.sv
// Word storage: synchronous write, combinational read, no reset; preload port loses to a functional write.
module dmem_array #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 15
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdat,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdat,
  input  logic              pre_en,
  input  logic [IDX_W-1:0]  pre_idx,
  input  logic [DATA_W-1:0] pre_dat
);
  logic [DATA_W-1:0] mem [2**IDX_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdat;
    end else if (pre_en) begin
      mem[pre_idx] <= pre_dat;
    end
  end

  assign rdat = mem[ridx];
endmodule

// File: rtl/dmem_stall_resp.sv
// Multi-cycle MEM-stage responder: Stall from accept until completion, then a one-cycle Done.
// Build option DMEM_ALIGN_CHECK_EN: odd-address accesses skip storage and complete with Err.
module dmem_stall_resp
  import dmem_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int LATENCY = DMEM_LAT_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  dmem_stall_resp_if.slave bus
);
  localparam int IDX_W = ADDR_W - 1;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              accept;
  logic              stall;
  logic              done;
  logic [IDX_W-1:0]  lat_idx;
  logic [DATA_W-1:0] lat_data;
  logic              lat_wr;
  logic              lat_mis;
  logic              acc_mis;
  logic              mem_we;
  logic [DATA_W-1:0] rd_data;

`ifdef DMEM_ALIGN_CHECK_EN
  assign acc_mis = bus.Addr[0];
  assign bus.Err = done & lat_mis;
`else
  logic unused_addr0;
  assign unused_addr0 = bus.Addr[0];
  assign acc_mis      = 1'b0;
  assign bus.Err      = 1'b0;
`endif

  // Stall is Mealy in IDLE so the MEM stage holds in the very cycle a request is taken.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    stall     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if ((bus.Rd | bus.Wr) & ~bus.Halt) begin
          accept    = 1'b1;
          stall     = 1'b1;
          cnt_nxt   = CNT_W'(LATENCY - 1);
          state_nxt = (LATENCY == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall   = 1'b1;
        cnt_nxt = cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_idx  <= '0;
      lat_data <= '0;
      lat_wr   <= 1'b0;
      lat_mis  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_idx  <= bus.Addr[ADDR_W-1:1];
        lat_data <= bus.DataIn;
        lat_wr   <= bus.Wr;
        lat_mis  <= acc_mis;
      end
    end
  end

  // A reset landing on the DONE cycle discards the pending write.
  assign mem_we = done & lat_wr & ~lat_mis & ~rst;

  dmem_array #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .we      (mem_we),
    .widx    (lat_idx),
    .wdat    (lat_data),
    .ridx    (lat_idx),
    .rdat    (rd_data),
    .pre_en  (bus.pre_en),
    .pre_idx (bus.pre_idx),
    .pre_dat (bus.pre_dat)
  );

  assign bus.Stall   = stall;
  assign bus.Done    = done;
  assign bus.DataOut = (done & ~lat_wr & ~lat_mis) ? rd_data : '0;
endmodule

// File: tb/tb_dmem_stall_resp.sv
// Bench: directed scenarios then random traffic, checked every cycle against an access-timeline model.
module tb_dmem_stall_resp;
  localparam int L = 4;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_stall_resp_if #(.DATA_W(16), .ADDR_W(16)) ifc ();

  dmem_stall_resp #(.DATA_W(16), .ADDR_W(16), .LATENCY(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int checks = 0;
  int errors = 0;

  // Model: memory image of words 0..63 and the age (cycles since accept) of the access in flight.
  logic [15:0] ref_mem  [64];
  logic [15:0] init_mem [64];
  int          age = -1;
  logic        p_wr, p_mis;
  logic [5:0]  p_idx;
  logic [15:0] p_data;

  logic        ob_stall, ob_done, ob_err;
  logic [15:0] ob_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic halt,
                       input logic [15:0] a, input logic [15:0] d);
    ifc.Rd     = rd;
    ifc.Wr     = wr;
    ifc.Halt   = halt;
    ifc.Addr   = a;
    ifc.DataIn = d;
  endtask

  // Called just after a falling edge with inputs applied; returns after the next falling edge.
  task automatic tick();
    logic        e_stall, e_done, e_err;
    logic [15:0] e_data;
    #1;
    e_stall = 1'b0;
    e_done  = 1'b0;
    e_err   = 1'b0;
    e_data  = 16'h0;
    if (age < 0) begin
      if ((ifc.Rd | ifc.Wr) & ~ifc.Halt) begin
        e_stall = 1'b1;
        age     = 0;
        p_wr    = ifc.Wr;
        p_idx   = ifc.Addr[6:1];
        p_data  = ifc.DataIn;
        p_mis   = ALIGN & ifc.Addr[0];
      end
    end else if (age < L) begin
      e_stall = 1'b1;
    end else begin
      e_done = 1'b1;
      e_err  = p_mis;
      e_data = (!p_wr && !p_mis) ? ref_mem[p_idx] : 16'h0;
    end
    ob_stall = ifc.Stall;
    ob_done  = ifc.Done;
    ob_err   = ifc.Err;
    ob_data  = ifc.DataOut;
    chk("stall", 32'(ob_stall), 32'(e_stall));
    chk("done",  32'(ob_done),  32'(e_done));
    chk("err",   32'(ob_err),   32'(e_err));
    chk("dout",  32'(ob_data),  32'(e_data));
    @(posedge clk);
    if (rst) begin
      age = -1;
    end else if (age == L) begin
      if (p_wr && !p_mis) ref_mem[p_idx] = p_data;
      age = -1;
    end else if (age >= 0) begin
      age++;
    end
    @(negedge clk);
  endtask

  // One access; during the busy phase junk requests are presented (optionally with Halt held).
  task automatic run_access(input logic rd, input logic wr, input logic [15:0] a,
                            input logic [15:0] d, input logic hold_halt,
                            output int lat, output logic [15:0] dout, output logic err);
    drive(rd, wr, 1'b0, a, d);
    tick();
    lat  = -1;
    dout = 16'h0;
    err  = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, 1'b1, hold_halt, a ^ 16'h0002, ~d);
      tick();
      if (ob_done) begin
        lat  = i;
        dout = ob_data;
        err  = ob_err;
        break;
      end
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  initial begin
    int          lat;
    logic [15:0] dout;
    logic        err;
    logic [15:0] v;
    int          seen;

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    ifc.pre_en  = 1'b0;
    ifc.pre_idx = '0;
    ifc.pre_dat = '0;
    @(negedge clk);

    for (int i = 0; i < 64; i++) begin
      v = (i == 32) ? 16'h5A5A : 16'($urandom);
      ifc.pre_en  = 1'b1;
      ifc.pre_idx = 15'(i);
      ifc.pre_dat = v;
      ref_mem[i]  = v;
      init_mem[i] = v;
      tick();
    end
    ifc.pre_en = 1'b0;
    tick();
    tick();
    chk("rst_stall", 32'(ob_stall), 32'd0);
    chk("rst_done",  32'(ob_done),  32'd0);
    chk("rst_dout",  32'(ob_data),  32'd0);
    chk("rst_err",   32'(ob_err),   32'd0);
    rst = 1'b0;
    tick();

    run_access(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, lat, dout, err);
    chk("wr_lat", 32'(lat), 32'd4);
    run_access(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, lat, dout, err);
    chk("rd_lat", 32'(lat), 32'd4);
    chk("rd_data", 32'(dout), 32'hBEEF);

    run_access(1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, lat, dout, err);
    chk("rdwr_lat", 32'(lat), 32'd4);
    chk("rdwr_dout", 32'(dout), 32'h0);
    run_access(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, lat, dout, err);
    chk("rdwr_readback", 32'(dout), 32'h1234);

    drive(1'b1, 1'b0, 1'b1, 16'h0010, 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_stall", 32'(ob_stall), 32'd0);
      chk("halt_done",  32'(ob_done),  32'd0);
    end

    run_access(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, lat, dout, err);
    chk("halt_busy_lat", 32'(lat), 32'd4);
    chk("halt_busy_data", 32'(dout), 32'hBEEF);

    drive(1'b0, 1'b1, 1'b0, 16'h0040, 16'hAAAA);
    tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ob_done) seen++;
    end
    chk("rst_no_done", 32'(seen), 32'd0);
    run_access(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, lat, dout, err);
    chk("rst_rd_data", 32'(dout), 32'(init_mem[32]));

    run_access(1'b0, 1'b1, 16'h0011, 16'hFFFF, 1'b0, lat, dout, err);
    chk("mis_lat", 32'(lat), 32'd4);
    chk("mis_err", 32'(err), 32'(ALIGN));
    run_access(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, lat, dout, err);
    chk("mis_readback", 32'(dout), ALIGN ? 32'hBEEF : 32'hFFFF);

    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 3) == 0, ($urandom % 3) == 0, ($urandom % 5) == 0,
            16'($urandom_range(0, 127)), 16'($urandom));
      rst = (($urandom % 60) == 0);
      tick();
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 8; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
